// File: rtl/fifo_step_player.sv
// -----------------------------------------------------------------------------
// fifo_step_player
//   Consumer end of the 32-bit motion-command FIFO. Pops one command word at a
//   time, plays it out as step/dir pulses for one motor axis and tracks the
//   absolute (two's complement) step position.
//
//   Command word: [31] dir, [30:16] step count N, [15:0] period P (clk cycles).
//   Effective period Pe = max(P, 2*PULSE_W). The FIFO read is registered: data
//   is valid the cycle after fifo_rd_en.
//
//   Optional feature macro: DIR_SETUP_EN
//     When defined, a SETUP state holding DIR_SETUP quiet cycles is inserted
//     between LATCH and RUN whenever the new command reverses direction.
//
// Ports:
//   clk        in   system clock, all flops on posedge
//   rst        in   synchronous reset, active-low
//   en         in   allow fetching new commands
//   abort      in   drop current command and return to IDLE
//   fifo_data  in   FIFO read data (valid the cycle after fifo_rd_en)
//   fifo_empty in   FIFO empty flag
//   fifo_rd_en out  FIFO pop request, one-cycle pulse
//   step       out  step pulse to driver
//   dir        out  direction to driver, 1 = positive
//   busy       out  high in any state other than IDLE
//   position   out  absolute step position, POS_W bits, two's complement
// -----------------------------------------------------------------------------
module fifo_step_player #(
  parameter int PULSE_W   = 4,
  parameter int POS_W     = 32,
  parameter int DIR_SETUP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             abort,
  input  logic [31:0]      fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic [POS_W-1:0] position
);

  localparam logic [15:0] PMIN      = 16'(2 * PULSE_W);
  localparam logic [16:0] PULSE_LIM = 17'(PULSE_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
`ifdef DIR_SETUP_EN
    S_SETUP = 3'd4,
`endif
    S_RUN   = 3'd3
  } state_t;

  state_t           r_state;
  logic [16:0]      r_pc;
  logic [16:0]      r_pe;
  logic [14:0]      r_rem;
  logic             r_dir;
  logic             r_step;
  logic             r_rd_en;
  logic             r_busy;
  logic [POS_W-1:0] r_pos;
`ifdef DIR_SETUP_EN
  logic [7:0]       r_setup;
  logic [7:0]       w_setup_nx;
`endif

  state_t           w_state_nx;
  logic [16:0]      w_pc_nx;
  logic [16:0]      w_pe_nx;
  logic [14:0]      w_rem_nx;
  logic             w_dir_nx;
  logic             w_step_nx;
  logic             w_rd_nx;
  logic             w_busy_nx;
  logic [POS_W-1:0] w_pos_nx;

  logic             w_cmd_dir;
  logic [14:0]      w_cmd_n;
  logic [15:0]      w_cmd_p;
  logic [16:0]      w_cmd_pe;

  assign w_cmd_dir = fifo_data[31];
  assign w_cmd_n   = fifo_data[30:16];
  assign w_cmd_p   = fifo_data[15:0];
  // Short periods are stretched so the pulse always gets an equal low time.
  assign w_cmd_pe  = (w_cmd_p < PMIN) ? {1'b0, PMIN} : {1'b0, w_cmd_p};

  // Next-state and next-counter logic.
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_pe_nx    = r_pe;
    w_rem_nx   = r_rem;
    w_dir_nx   = r_dir;
`ifdef DIR_SETUP_EN
    w_setup_nx = r_setup;
`endif
    case (r_state)
      S_IDLE: begin
        if (en && !fifo_empty) begin
          w_state_nx = S_READ;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_READ: begin
        w_state_nx = S_LATCH;
      end
      S_LATCH: begin
        w_rem_nx = w_cmd_n;
        w_pe_nx  = w_cmd_pe;
        if (w_cmd_n == 15'd0) begin
          w_state_nx = S_IDLE;
        end else begin
          w_dir_nx = w_cmd_dir;
`ifdef DIR_SETUP_EN
          if (w_cmd_dir != r_dir) begin
            w_state_nx = S_SETUP;
            w_setup_nx = 8'd0;
          end else begin
            w_state_nx = S_RUN;
            w_pc_nx    = 17'd0;
          end
`else
          w_state_nx = S_RUN;
          w_pc_nx    = 17'd0;
`endif
        end
      end
`ifdef DIR_SETUP_EN
      S_SETUP: begin
        if (r_setup == 8'(DIR_SETUP - 1)) begin
          w_state_nx = S_RUN;
          w_pc_nx    = 17'd0;
        end else begin
          w_setup_nx = r_setup + 8'd1;
        end
      end
`endif
      S_RUN: begin
        if (r_pc == (r_pe - 17'd1)) begin
          w_rem_nx = r_rem - 15'd1;
          w_pc_nx  = 17'd0;
          if (r_rem == 15'd1) begin
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_RUN;
          end
        end else begin
          w_pc_nx = r_pc + 17'd1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    // Abort overrides every transition, including a pending fetch.
    if (abort) begin
      w_state_nx = S_IDLE;
      w_rem_nx   = 15'd0;
      w_pc_nx    = 17'd0;
`ifdef DIR_SETUP_EN
      w_setup_nx = 8'd0;
`endif
    end else begin
      w_state_nx = w_state_nx;
    end
  end

  // Output values for the next cycle, derived from the next state so that the
  // registered outputs line up with the state they describe.
  always_comb begin
    w_rd_nx   = (r_state == S_IDLE) && (w_state_nx == S_READ);
    w_busy_nx = (w_state_nx != S_IDLE);
    w_step_nx = (w_state_nx == S_RUN) && (w_pc_nx < PULSE_LIM);
    // pc returning to 0 inside RUN marks a rising step edge.
    if ((w_state_nx == S_RUN) && (w_pc_nx == 17'd0)) begin
      if (w_dir_nx) begin
        w_pos_nx = r_pos + POS_W'(1);
      end else begin
        w_pos_nx = r_pos - POS_W'(1);
      end
    end else begin
      w_pos_nx = r_pos;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= 17'd0;
      r_pe    <= 17'd0;
      r_rem   <= 15'd0;
      r_dir   <= 1'b0;
      r_step  <= 1'b0;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_pos   <= '0;
`ifdef DIR_SETUP_EN
      r_setup <= 8'd0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_pe    <= w_pe_nx;
      r_rem   <= w_rem_nx;
      r_dir   <= w_dir_nx;
      r_step  <= w_step_nx;
      r_rd_en <= w_rd_nx;
      r_busy  <= w_busy_nx;
      r_pos   <= w_pos_nx;
`ifdef DIR_SETUP_EN
      r_setup <= w_setup_nx;
`endif
    end
  end

  assign fifo_rd_en = r_rd_en;
  assign step       = r_step;
  assign dir        = r_dir;
  assign busy       = r_busy;
  assign position   = r_pos;

endmodule

// File: doc/fifo_step_player.md
Name: fifo_step_player

Overview:
- Consumer end of the 32-bit motion-command FIFO. Pops one command word at a time and plays it out as step/dir pulses for one motor axis.
- Tracks absolute position. Sits between the command FIFO read port and the motor driver pins on the CPLD.
- Handles the FIFO's registered read: data is valid on the cycle after the read-enable cycle.

Parameters:
- PULSE_W, 4: step pulse high time in clk cycles, 1..255.
- POS_W, 32: position counter width.
- DIR_SETUP, 8: dir-to-step setup cycles, 1..255; used only with DIR_SETUP_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- en  in  1  allow fetching new commands
- abort  in  1  drop current command and return to IDLE
- fifo_data  in  32  FIFO read data, valid the cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO pop request, one-cycle pulse
- step  out  1  step pulse to driver
- dir  out  1  direction to driver; 1 = positive
- busy  out  1  high in any state other than IDLE
- position  out  POS_W  signed absolute step position

Behaviour:
- Clock and reset: single clock clk, all flops on posedge clk. Reset is synchronous and active-low: rst=0 at a posedge resets everything.
- Reset values: state=IDLE, fifo_rd_en=0, step=0, dir=0, busy=0, position=0, internal counters=0.
- Reset mid-command discards the command. No further step edges are produced.
- Command word fields:
  - [31] = dir
  - [30:16] = step count N, 15 bits unsigned
  - [15:0] = period P in clk cycles
- Effective period Pe = max(P, 2*PULSE_W). The comparison is 16-bit unsigned; Pe is held in a 17-bit register.
- All outputs are registered.
- IDLE: if en=1 and fifo_empty=0, assert fifo_rd_en for exactly one cycle and go to READ. Otherwise stay.
- READ: fifo_rd_en deasserts. Go to LATCH.
- LATCH: capture fifo_data into dir_next, N and Pe.
  - If N=0: command is consumed with no pulses; go to IDLE.
  - Otherwise: dir is updated from dir_next, and the state goes to RUN with the period counter cleared.
- RUN:
  - Period counter pc counts 0..Pe-1.
  - step=1 while pc<PULSE_W, else 0.
  - On the cycle step rises (pc=0), position increments by 1 if dir=1 and decrements by 1 if dir=0, modulo 2^POS_W.
  - At pc=Pe-1: decrement remaining steps. If remaining reaches 0, go to IDLE; otherwise pc wraps to 0.
- Latency: IDLE with en=1 and fifo_empty=0 in cycle 0 gives fifo_rd_en=1 in cycle 1, LATCH in cycle 2, first step=1 in cycle 3.
- Command gap: minimum gap between the last period end and the next command's first step rise is 3 cycles.
- en=0 mid-command: the current command completes. No new fetch is made.
- abort=1: takes priority over everything except reset.
  - Next state is IDLE; step=0 on the next cycle.
  - Remaining steps are discarded; position keeps its value.
  - A fetch already issued (READ/LATCH) is consumed and dropped. The popped word is lost.
- Simultaneous abort and IDLE fetch condition: abort wins, no fifo_rd_en.
- fifo_rd_en is never asserted while fifo_empty=1. It is never asserted twice per command.

Optional Feature:
- Macro: DIR_SETUP_EN.
- Defined: adds a SETUP state between LATCH and RUN, entered only when dir_next differs from the current dir.
  - dir changes on entry to SETUP.
  - The state holds DIR_SETUP cycles with step=0, then goes to RUN.
  - Abort in SETUP goes to IDLE.
  - First-step latency after a direction change becomes 3+DIR_SETUP cycles.
- Undefined: no SETUP state; dir changes at LATCH and RUN follows immediately, as above.

Test Plan:
1. Reset release, FIFO word 0x8003_000A with en=1 -> fifo_rd_en single pulse; 3 step pulses, each 4 cycles high and 10-cycle period; first rise 3 cycles after fetch start; dir=1; position=3; busy=0 after 30 RUN cycles.
2. Word 0x0002_0003 (P=3 < 2*PULSE_W) -> Pe=8; 2 pulses 8 cycles apart; position decrements from 3 to 1.
3. Word with N=0 (0x0000_0020) then 0x8001_0010 -> first word popped, no pulse; second word plays 1 pulse 3 cycles after its own fetch.
4. abort=1 during the second pulse of a 5-step command -> step=0 next cycle; position reflects 2 steps; IDLE; next FIFO word fetched normally.
5. en=0 asserted mid-command with 2 words queued -> current command completes; fifo_rd_en stays 0 until en=1; fifo_empty=1 never yields fifo_rd_en.
6. DIR_SETUP_EN defined, dir 1 then 0 commands -> 8 quiet cycles after dir toggles before the first step; same-dir commands get no SETUP delay. Also POS_W wrap: position 0x7FFF_FFFF plus 1 step -> 0x8000_0000.
